// File: rtl/normal_shader.sv
// Four-stage Lambertian normal shader feeding an 8-entry pixel FIFO with raster position tracking.
// Optional debug colouring of the raw normal is enabled by defining NORMAL_SHADER_NRM_COLOR_EN.
module normal_shader #(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int LX      = 0,
  parameter int LY      = 0,
  parameter int LZ      = 16384,
  parameter int AMBIENT = 32,
  parameter int BASE_R  = 255,
  parameter int BASE_G  = 255,
  parameter int BASE_B  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] normal_x,
  input  logic [31:0] normal_y,
  input  logic [31:0] normal_z,
`ifdef NORMAL_SHADER_NRM_COLOR_EN
  input  logic        dbg_nrm,
`endif
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [23:0] pix_rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_last,
  output logic        ovf
);

  localparam logic signed [63:0] LX_W     = 64'(LX);
  localparam logic signed [63:0] LY_W     = 64'(LY);
  localparam logic signed [63:0] LZ_W     = 64'(LZ);
  localparam logic [7:0]         AMB      = 8'(AMBIENT);
  localparam logic [7:0]         AMB_SPAN = 8'(255 - AMBIENT);
  localparam logic [15:0]        BR       = 16'(BASE_R);
  localparam logic [15:0]        BG       = 16'(BASE_G);
  localparam logic [15:0]        BB       = 16'(BASE_B);
  localparam logic [3:0]         DEPTH    = 4'd8;

  logic signed [31:0] nx_s, ny_s, nz_s;
  assign nx_s = normal_x;
  assign ny_s = normal_y;
  assign nz_s = normal_z;

  logic               s1_v, s2_v, s3_v, s4_v;
  logic signed [63:0] s1_px, s1_py, s1_pz;
  logic signed [63:0] s2_dot;
  logic [7:0]         s3_int;
  logic [23:0]        s4_rgb;
  logic [14:0]        dot_cl;

`ifdef NORMAL_SHADER_NRM_COLOR_EN
  logic [31:0] s1_nx, s1_ny, s1_nz;
  logic        s1_dbg, s2_dbg, s3_dbg;
  logic [23:0] s2_nrm, s3_nrm;

  // Maps a Q2.14 component in [-1, 1] onto 0..255, saturating outside that range.
  function automatic logic [7:0] nrm_chan(input logic signed [31:0] n);
    logic signed [33:0] t;
    t = (34'(n) + 34'sd16384) >>> 7;
    if (t < 0)                 return 8'd0;
    else if (t > 34'sd255)     return 8'd255;
    else                       return t[7:0];
  endfunction
`endif

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    dot_cl = '0;
    if (s2_dot < 0)               dot_cl = '0;
    else if (s2_dot > 64'sd16384) dot_cl = 15'd16384;
    else                          dot_cl = 15'(s2_dot);
  end

  // NOTE: all pipeline and control state updates with non-blocking assignments.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s3_v   <= 1'b0;
      s4_v   <= 1'b0;
      s1_px  <= '0;
      s1_py  <= '0;
      s1_pz  <= '0;
      s2_dot <= '0;
      s3_int <= '0;
      s4_rgb <= '0;
`ifdef NORMAL_SHADER_NRM_COLOR_EN
      s1_nx  <= '0;
      s1_ny  <= '0;
      s1_nz  <= '0;
      s1_dbg <= 1'b0;
      s2_dbg <= 1'b0;
      s3_dbg <= 1'b0;
      s2_nrm <= '0;
      s3_nrm <= '0;
`endif
    end else begin
      s1_v   <= in_valid;
      s1_px  <= 64'(nx_s) * LX_W;
      s1_py  <= 64'(ny_s) * LY_W;
      s1_pz  <= 64'(nz_s) * LZ_W;
      s2_v   <= s1_v;
      s2_dot <= (s1_px + s1_py + s1_pz) >>> 14;
      s3_v   <= s2_v;
      s3_int <= AMB + 8'((23'(AMB_SPAN) * 23'(dot_cl)) >> 14);
      s4_v   <= s3_v;
      s4_rgb <= {8'((BR * 16'(s3_int)) >> 8),
                 8'((BG * 16'(s3_int)) >> 8),
                 8'((BB * 16'(s3_int)) >> 8)};
`ifdef NORMAL_SHADER_NRM_COLOR_EN
      s1_nx  <= normal_x;
      s1_ny  <= normal_y;
      s1_nz  <= normal_z;
      s1_dbg <= dbg_nrm;
      s2_dbg <= s1_dbg;
      s3_dbg <= s2_dbg;
      s2_nrm <= {nrm_chan(s1_nx), nrm_chan(s1_ny), nrm_chan(s1_nz)};
      s3_nrm <= s2_nrm;
      if (s3_dbg) s4_rgb <= s3_nrm;
`endif
    end
  end

  logic [23:0] mem [DEPTH];
  logic [2:0]  wr_ptr, rd_ptr, rd_nxt;
  logic [3:0]  count, cnt_left;
  logic        pop, accept;
  logic [23:0] head_nxt;

  assign pix_valid = (count != 4'd0);
  assign pix_last  = pix_valid && (pix_x == 10'(H_RES - 1)) && (pix_y == 10'(V_RES - 1));

  // pix_rgb is a register mirroring the head so it holds its value once the FIFO drains.
  always_comb begin
    pop      = pix_valid & pix_ready;
    accept   = s4_v & ((count != DEPTH) | pop);
    rd_nxt   = rd_ptr + 3'(pop);
    cnt_left = count - 4'(pop);
    head_nxt = pix_rgb;
    if (cnt_left != 4'd0) head_nxt = mem[rd_nxt];
    else if (accept)      head_nxt = s4_rgb;
  end

  // NOTE: the storage array carries no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= s4_rgb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pix_rgb <= '0;
      pix_x   <= '0;
      pix_y   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 3'd1;
      rd_ptr  <= rd_nxt;
      count   <= cnt_left + 4'(accept);
      pix_rgb <= head_nxt;
      if (s4_v && !accept) ovf <= 1'b1;
      if (pop) begin
        if (pix_x == 10'(H_RES - 1)) begin
          pix_x <= '0;
          pix_y <= (pix_y == 10'(V_RES - 1)) ? 10'd0 : pix_y + 10'd1;
        end else begin
          pix_x <= pix_x + 10'd1;
        end
      end
    end
  end

endmodule

// File: doc/normal_shader.md
NORMAL_SHADER -- requirements
Module: normal_shader

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, lines per frame.
REQ-003 SHALL have parameters LX, LY, LZ, defaults 0, 0, 16384, signed Q2.14 unit light direction.
REQ-004 SHALL have parameter AMBIENT, default 32, 8-bit ambient intensity floor.
REQ-005 SHALL have parameters BASE_R, BASE_G, BASE_B, default 255 each, 8-bit surface colour.
REQ-006 SHALL have ports, in this order:
 - clk  in  1  clock; reset rst, asynchronous, active-low
 - rst  in  1  asynchronous active-low reset
 - in_valid  in  1  normal sample valid (driven by intersector out_VALID)
 - normal_x, normal_y, normal_z  in  32 each  signed Q18.14 unit normal
 - pix_valid  out  1  output pixel available
 - pix_ready  in  1  downstream accepts pixel
 - pix_rgb  out  24  {R,G,B}, 8 bits each
 - pix_x  out  10  column of the presented pixel
 - pix_y  out  10  row of the presented pixel
 - pix_last  out  1  presented pixel is the last of the frame
 - ovf  out  1  sticky overflow, a result was dropped

Function
REQ-007 SHALL accept one sample on every cycle with in_valid=1; there is no upstream backpressure.
REQ-008 Stage 1 SHALL register the three signed 64-bit products normal_x*LX, normal_y*LY, normal_z*LZ.
REQ-009 Stage 2 SHALL register dot = (sum of the three products) >>> 14, arithmetic.
REQ-010 Stage 3 SHALL clamp dot to [0, 16384] and register intensity = AMBIENT + ((255-AMBIENT)*dot_clamped) >> 14, range AMBIENT..255.
REQ-011 Stage 4 SHALL register each channel as (BASE_c*intensity) >> 8, truncated.
REQ-012 Valid SHALL travel alongside data; a result SHALL be written into an 8-entry output FIFO exactly 4 cycles after its in_valid.
REQ-013 pix_valid SHALL equal FIFO not-empty; pix_rgb SHALL show the FIFO head; the head pops on pix_valid & pix_ready.
REQ-014 A simultaneous push and pop on a full FIFO SHALL succeed, with no drop.
REQ-015 A push into a full FIFO with no pop SHALL discard the result, leave FIFO contents unchanged, and set ovf until reset.
REQ-016 pix_x and pix_y SHALL be position counters for the head pixel and SHALL advance only on a handshake.
REQ-017 On a handshake, pix_x SHALL increment; at H_RES-1 it SHALL wrap to 0 and pix_y SHALL increment; pix_y SHALL wrap from V_RES-1 to 0.
REQ-018 pix_last SHALL be 1 when pix_valid & pix_x==H_RES-1 & pix_y==V_RES-1.
REQ-019 When pix_valid=0, pix_rgb SHALL hold its last value and the counters SHALL hold.

Reset
REQ-020 rst=0 SHALL immediately clear:
 - pipeline valids and data
 - FIFO pointers and count
 - pix_x, pix_y
 - ovf, pix_valid, pix_last, pix_rgb
REQ-021 Samples in flight during reset SHALL be lost; the first sample after release SHALL appear after 5 cycles, at position (0,0).

Configuration
REQ-022 Macro NORMAL_SHADER_NRM_COLOR_EN, when defined, SHALL add input port dbg_nrm (1 bit, after normal_z).
REQ-023 With dbg_nrm=1, stage 4 SHALL output channel_c = clamp((n_c + 16384) >> 7, 0, 255), using the stage-1-delayed normal, at the same latency.
REQ-024 Without the macro, there SHALL be no dbg_nrm port and shading SHALL always be Lambertian.

Verification
REQ-025 Defaults, normal (0,0,16384) -> pix_rgb=24'hFEFEFE, 5 cycles after in_valid, with pix_ready=1.
REQ-026 Normal (0,0,-16384) -> dot clamps to 0, intensity 32 -> pix_rgb=24'h1F1F1F.
REQ-027 Normal (11585,0,11585) -> dot 11585, intensity 189 -> pix_rgb=24'hBCBCBC.
REQ-028 pix_ready=0, 10 back-to-back samples -> 8 pixels held, ovf=1; releasing pix_ready then yields 8 pixels in order.
REQ-029 H_RES=4, V_RES=2, 8 samples -> coordinates (0,0)..(3,1); pix_last on the 8th only; the 9th sample -> (0,0).
REQ-030 Macro defined, dbg_nrm=1, normal (16384,0,-16384) -> pix_rgb=24'hFF8000.
